// File: rtl/lycan_pkg.sv
// rtl/lycan_pkg.sv - shared types and header helpers for the USB TX arbiter
package lycan_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HEADER,
    ARB_BURST
  } arb_state_t;

  localparam int HDR_IDX_MSB = 31;
  localparam int HDR_IDX_LSB = 29;
  localparam int HDR_LEN_W   = 16;

  // Header word: source index in the top bits, burst length in the low bits
  function automatic logic [31:0] make_header(input logic [2:0] idx,
                                              input logic [HDR_LEN_W-1:0] len);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_IDX_MSB:HDR_IDX_LSB] = idx;
    hdr[HDR_LEN_W-1:0] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/usb_tx_arbiter_rr_select.sv
// rtl/usb_tx_arbiter_rr_select.sv - combinational round-robin pick of the first
// requester at or above ptr, wrapping modulo NUM_PERIPHS
module rr_priority_select
  import lycan_pkg::*;
#(
  parameter int NUM_PERIPHS = 8
) (
  input  logic [NUM_PERIPHS-1:0] req,
  input  logic [2:0]             ptr,
  output logic [2:0]             idx,
  output logic                   valid
);

  logic [7:0] req8;
  logic [3:0] pos;

  always_comb begin
    req8 = '0;
    req8[NUM_PERIPHS-1:0] = req;
  end

  // Walk from the farthest offset down so the nearest requester wins last
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = NUM_PERIPHS - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'(NUM_PERIPHS)) pos = pos - 4'(NUM_PERIPHS);
      if (req8[pos[2:0]]) begin
        idx   = pos[2:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - round-robin scheduler of peripheral TX FIFOs onto the
// single USB write path; emits a header word then up to MAX_BURST data words
module usb_tx_arbiter
  import lycan_pkg::*;
#(
  parameter int NUM_PERIPHS = 8,
  parameter int MAX_BURST   = 64,
  parameter int COUNT_W     = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_PERIPHS-1:0]         periph_empty,
  input  logic [NUM_PERIPHS*COUNT_W-1:0] periph_count,
  input  logic [NUM_PERIPHS*32-1:0]      periph_data,
  output logic [NUM_PERIPHS-1:0]         periph_rd_en,
  input  logic                           out_full,
  output logic [31:0]                    out_data,
  output logic                           out_wr,
  output logic                           busy,
  output logic [2:0]                     grant_idx
);

  localparam logic [31:0] MAX_B = 32'(MAX_BURST);

  arb_state_t   state, state_nx;
  logic [2:0]   rr_ptr;
  logic [15:0]  len, remaining;
  logic [2:0]   sel_idx;
  logic         sel_valid;
  logic [15:0]  grant_len;
  logic [31:0]  sel_count;
  logic [7:0]   empty8;
  logic [7:0]   rd8;
  logic [31:0]        data_arr [8];
  logic [COUNT_W-1:0] cnt_arr  [8];

  // Pad per-peripheral views to 8 entries so a 3-bit index is always in range
  for (genvar i = 0; i < 8; i++) begin : g_slot
    if (i < NUM_PERIPHS) begin : g_used
      assign data_arr[i] = periph_data[i*32 +: 32];
      assign cnt_arr[i]  = periph_count[i*COUNT_W +: COUNT_W];
    end else begin : g_pad
      assign data_arr[i] = '0;
      assign cnt_arr[i]  = '0;
    end
  end

  always_comb begin
    empty8 = '1;
    empty8[NUM_PERIPHS-1:0] = periph_empty;
  end

  rr_priority_select #(.NUM_PERIPHS(NUM_PERIPHS)) u_select (
    .req   (~periph_empty),
    .ptr   (rr_ptr),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // A non-empty FIFO reporting zero occupancy still holds at least one word
  always_comb begin
    sel_count = 32'(cnt_arr[sel_idx]);
    if (sel_count == 32'd0)   grant_len = 16'd1;
    else if (sel_count > MAX_B) grant_len = MAX_B[15:0];
    else                      grant_len = sel_count[15:0];
  end

  always_comb begin
    state_nx = state;
    out_wr   = 1'b0;
    out_data = '0;
    rd8      = '0;
    case (state)
      ARB_IDLE: begin
        if (en && sel_valid) state_nx = ARB_HEADER;
      end
      ARB_HEADER: begin
        out_data = make_header(grant_idx, len);
        if (!out_full) begin
          out_wr   = 1'b1;
          state_nx = ARB_BURST;
        end
      end
      ARB_BURST: begin
        out_data = data_arr[grant_idx];
        if (!out_full && !empty8[grant_idx]) begin
          out_wr         = 1'b1;
          rd8[grant_idx] = 1'b1;
          if (remaining == 16'd1) state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
    if (rst) begin
      out_wr   = 1'b0;
      out_data = '0;
      rd8      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      len       <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ARB_IDLE: begin
          if (en && sel_valid) begin
            grant_idx <= sel_idx;
            len       <= grant_len;
          end
        end
        ARB_HEADER: begin
          if (!out_full) remaining <= len;
        end
        ARB_BURST: begin
          if (out_wr) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1)
              rr_ptr <= (grant_idx == 3'(NUM_PERIPHS - 1)) ? 3'd0 : grant_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign periph_rd_en = rd8[NUM_PERIPHS-1:0];
  assign busy         = (state != ARB_IDLE);

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb/tb_usb_tx_arbiter.sv - scoreboard bench for usb_tx_arbiter with modelled
// first-word-fall-through peripheral FIFOs
module tb_usb_tx_arbiter;
  localparam int N  = 8;
  localparam int MB = 4;
  localparam int CW = 11;

  logic            clk = 1'b0;
  logic            rst, en, out_full, out_wr, busy;
  logic [N-1:0]    periph_empty, periph_rd_en;
  logic [N*CW-1:0] periph_count;
  logic [N*32-1:0] periph_data;
  logic [31:0]     out_data;
  logic [2:0]      grant_idx;

  usb_tx_arbiter #(.NUM_PERIPHS(N), .MAX_BURST(MB), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .periph_empty(periph_empty),
    .periph_count(periph_count), .periph_data(periph_data),
    .periph_rd_en(periph_rd_en), .out_full(out_full), .out_data(out_data),
    .out_wr(out_wr), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo [N][$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];
  int          total = 0, bad = 0, cyc = 0, viol = 0;
  int          pops [N];
  logic [N-1:0] pop_mask = '0;

  function automatic logic [31:0] word(input int i, input int tag, input int k);
    return {4'(i), 4'(tag), 8'h5A, 16'(k)};
  endfunction

  function automatic void refresh();
    for (int i = 0; i < N; i++) begin
      periph_empty[i] = (fifo[i].size() == 0);
      periph_count[i*CW +: CW] = CW'(fifo[i].size());
      periph_data[i*32 +: 32] = (fifo[i].size() != 0) ? fifo[i][0] : 32'd0;
    end
  endfunction

  task automatic push(input int i, input logic [31:0] w);
    fifo[i].push_back(w);
    refresh();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pop_mask = periph_rd_en;
    if (out_wr) begin
      got_q.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    if (out_full && (out_wr || periph_rd_en != '0)) viol++;
    if (periph_rd_en != '0 && !out_wr) viol++;
    if ($countones(periph_rd_en) > 1) viol++;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (pop_mask[i] && fifo[i].size() != 0) begin
        void'(fifo[i].pop_front());
        pops[i]++;
      end
    refresh();
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; out_full = 1'b0;
    for (int i = 0; i < N; i++) fifo[i].delete();
    refresh();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (got_q.size() >= target && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int act;
    do_reset();
    en = 1'b1;
    @(negedge clk);
    total++; if ({busy, out_wr} !== 2'b00) begin bad++; $display("FAIL reset_flags busy/wr=%b want 00", {busy, out_wr}); end
    total++; if (periph_rd_en !== '0) begin bad++; $display("FAIL reset_rd_en got=%h want 0", periph_rd_en); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h want 0", out_data); end
    total++; if ({grant_idx, dut.rr_ptr} !== 6'd0) begin bad++; $display("FAIL reset_grant_ptr got=%h want 0", {grant_idx, dut.rr_ptr}); end
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || out_wr || periph_rd_en != '0) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL idle_activity got=%0d want 0", act); end
  endtask

  task automatic test_single();
    int pc, p0, v0, gc;
    logic [31:0] g, e;
    bit ok;
    p0 = pops[2]; v0 = viol;
    @(posedge clk); #1;
    pc = cyc;
    push(2, 32'hAAAA_0001); push(2, 32'hBBBB_0002); push(2, 32'hCCCC_0003);
    exp_q.push_back(32'h4000_0003);
    exp_q.push_back(32'hAAAA_0001); exp_q.push_back(32'hBBBB_0002); exp_q.push_back(32'hCCCC_0003);
    wait_writes(4, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d words want 4", got_q.size()); end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      gc = (got_cyc.size() != 0) ? got_cyc.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL single_word%0d got=%h want %h", k, g, e); end
      total++; if (gc !== pc + 1 + k) begin bad++; $display("FAIL single_cycle%0d got=%0d want %0d", k, gc, pc + 1 + k); end
    end
    total++; if (pops[2] - p0 !== 3) begin bad++; $display("FAIL single_pops got=%0d want 3", pops[2] - p0); end
    total++; if (dut.rr_ptr !== 3'd3) begin bad++; $display("FAIL single_rr_ptr got=%0d want 3", dut.rr_ptr); end
    total++; if (viol !== v0) begin bad++; $display("FAIL single_strobe_rules got=%0d want %0d", viol, v0); end
  endtask

  task automatic test_burst_cap();
    int pc, gc;
    logic [31:0] g, e;
    bit ok;
    @(posedge clk); #1;
    pc = cyc;
    for (int k = 0; k < 10; k++) push(0, word(0, 1, k));
    for (int k = 0; k < 10; k++) begin
      if (k == 0 || k == 4) exp_q.push_back(32'h0000_0004);
      if (k == 8) exp_q.push_back(32'h0000_0002);
      exp_q.push_back(word(0, 1, k));
    end
    wait_writes(13, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL cap_timeout got=%0d words want 13", got_q.size()); end
    for (int k = 0; k < 13; k++) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      gc = (got_cyc.size() != 0) ? got_cyc.pop_front() : -1;
      total++; if (g !== e) begin bad++; $display("FAIL cap_word%0d got=%h want %h", k, g, e); end
      if (k == 0 || k == 5 || k == 10) begin
        total++; if (gc !== pc + 1 + (k / 5) * 6) begin bad++; $display("FAIL cap_hdr_cycle%0d got=%0d want %0d", k, gc, pc + 1 + (k / 5) * 6); end
      end
    end
    total++; if (dut.rr_ptr !== 3'd1) begin bad++; $display("FAIL cap_rr_ptr got=%0d want 1", dut.rr_ptr); end
  endtask

  task automatic test_fairness();
    int cnt [N];
    int sent [N];
    int order[$];
    int ptr, j, l;
    logic [31:0] g, e;
    logic [31:0] gl[$];
    bit ok;
    @(posedge clk); #1;
    push(5, word(5, 2, 0));
    exp_q.push_back(32'hA000_0001); exp_q.push_back(word(5, 2, 0));
    wait_writes(2, 50, ok);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      void'(got_cyc.pop_front());
      total++; if (g !== e) begin bad++; $display("FAIL fair_prime got=%h want %h", g, e); end
    end
    total++; if (dut.rr_ptr !== 3'd6) begin bad++; $display("FAIL fair_rr_ptr got=%0d want 6", dut.rr_ptr); end

    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; sent[i] = 0; end
    for (int k = 0; k < 20; k++) begin
      push(1, word(1, 3, k)); push(5, word(5, 3, k)); push(7, word(7, 3, k));
    end
    cnt[1] = 20; cnt[5] = 20; cnt[7] = 20;
    ptr = 6;
    while (cnt[1] + cnt[5] + cnt[7] != 0) begin
      j = ptr;
      for (int k = 0; k < N; k++) begin
        j = (ptr + k) % N;
        if (cnt[j] != 0) break;
      end
      l = (cnt[j] > MB) ? MB : cnt[j];
      order.push_back(j);
      exp_q.push_back({3'(j), 13'b0, 16'(l)});
      for (int k = 0; k < l; k++) exp_q.push_back(word(j, 3, sent[j] + k));
      sent[j] += l; cnt[j] -= l;
      ptr = (j + 1) % N;
    end
    wait_writes(exp_q.size(), 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL fair_timeout got=%0d words want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() != 0; k++) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      if (got_cyc.size() != 0) void'(got_cyc.pop_front());
      gl.push_back(g);
      total++; if (g !== e) begin bad++; $display("FAIL fair_word%0d got=%h want %h", k, g, e); end
    end
    for (int p = 0; p < 5; p++) begin
      l = (p % 3 == 0) ? 7 : (p % 3 == 1) ? 1 : 5;
      g = gl[5 * p];
      total++; if (g[31:29] !== 3'(l)) begin bad++; $display("FAIL fair_grant%0d got=%0d want %0d", p, g[31:29], l); end
    end
  endtask

  task automatic test_backpressure();
    int p0, v0;
    logic [31:0] g, e;
    p0 = pops[3]; v0 = viol;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) push(3, word(3, 4, k));
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 0) exp_q.push_back(32'h6000_0004);
      exp_q.push_back(word(3, 4, k));
    end
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      out_full = ~out_full;
      if (c > 2 && got_q.size() >= 10 && !busy) break;
    end
    out_full = 1'b0;
    for (int k = 0; exp_q.size() != 0; k++) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      if (got_cyc.size() != 0) void'(got_cyc.pop_front());
      total++; if (g !== e) begin bad++; $display("FAIL bp_word%0d got=%h want %h", k, g, e); end
    end
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL bp_extra got=%0d want 0", got_q.size()); end
    total++; if (pops[3] - p0 !== 8) begin bad++; $display("FAIL bp_pops got=%0d want 8", pops[3] - p0); end
    total++; if (viol !== v0) begin bad++; $display("FAIL bp_strobe_while_full got=%0d want %0d", viol, v0); end
  endtask

  task automatic test_en_drop_reset();
    logic [31:0] g, e;
    bit ok;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) push(4, word(4, 5, k));
    exp_q.push_back(32'h8000_0004);
    for (int k = 0; k < 4; k++) exp_q.push_back(word(4, 5, k));
    for (int c = 0; c < 50 && got_q.size() < 2; c++) @(negedge clk);
    @(posedge clk); #1;
    en = 1'b0;
    wait_writes(5, 50, ok);
    repeat (20) @(negedge clk);
    total++; if (got_q.size() !== 5) begin bad++; $display("FAIL endrop_count got=%0d want 5", got_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL endrop_busy got=%b want 0", busy); end
    total++; if (fifo[4].size() !== 1) begin bad++; $display("FAIL endrop_left got=%0d want 1", fifo[4].size()); end
    @(posedge clk); #1;
    en = 1'b1;
    exp_q.push_back(32'h8000_0001); exp_q.push_back(word(4, 5, 4));
    wait_writes(7, 50, ok);
    for (int k = 0; exp_q.size() != 0; k++) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      if (got_cyc.size() != 0) void'(got_cyc.pop_front());
      total++; if (g !== e) begin bad++; $display("FAIL endrop_word%0d got=%h want %h", k, g, e); end
    end

    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) push(6, word(6, 6, k));
    exp_q.push_back(32'hC000_0004); exp_q.push_back(word(6, 6, 0)); exp_q.push_back(word(6, 6, 1));
    for (int c = 0; c < 50 && got_q.size() < 3; c++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({busy, out_wr} !== 2'b00) begin bad++; $display("FAIL rst_mid_flags busy/wr=%b want 00", {busy, out_wr}); end
    total++; if (periph_rd_en !== '0) begin bad++; $display("FAIL rst_mid_rd_en got=%h want 0", periph_rd_en); end
    total++; if ({grant_idx, dut.rr_ptr} !== 6'd0) begin bad++; $display("FAIL rst_mid_grant_ptr got=%h want 0", {grant_idx, dut.rr_ptr}); end
    for (int k = 0; exp_q.size() != 0; k++) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      total++; if (g !== e) begin bad++; $display("FAIL rst_mid_word%0d got=%h want %h", k, g, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; out_full = 1'b0;
    for (int i = 0; i < N; i++) pops[i] = 0;
    refresh();
    test_reset();
    test_single();
    test_burst_cap();
    test_fairness();
    test_backpressure();
    test_en_drop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
